rename_stage: RTL

Register-rename stage sitting directly downstream of the decode stage in the out-of-order core. It takes decoded architectural register fields, maps them to physical registers through a register alias table (RAT), and allocates a fresh physical destination from a circular free list. Its output is registered for the dispatch stage. Physical registers return to the free list from the retire path. Branch checkpointing and flush recovery are out of scope for this block.

---
 rtl/rename_stage_if.sv | 44 ++++
 rtl/rename_stage.sv | 122 ++++++++++++
 2 files changed

// File: rtl/rename_stage_if.sv
// Rename stage bus: decode-side request, dispatch-side renamed result,
// and the retire-side physical register return path.
interface rename_stage_if #(
  parameter int AREG_W = 5,
  parameter int PREG_W = 6
);
  // Decode -> rename
  logic              in_valid;
  logic              in_ready;
  logic [AREG_W-1:0] srcReg1;
  logic [AREG_W-1:0] srcReg2;
  logic [AREG_W-1:0] destReg;
  logic              regWrite;

  // Rename -> dispatch
  logic              out_valid;
  logic              out_ready;
  logic [PREG_W-1:0] out_psrc1;
  logic [PREG_W-1:0] out_psrc2;
  logic [PREG_W-1:0] out_pdest;
  logic [PREG_W-1:0] out_pdest_old;
  logic              out_regWrite;

  // Retire -> rename
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic [PREG_W:0]   free_count;

  // Surrounding pipeline (decode, dispatch, retire) drives the requests
  modport master (
    output in_valid, srcReg1, srcReg2, destReg, regWrite,
    output out_ready, free_valid, free_preg,
    input  in_ready, out_valid, out_psrc1, out_psrc2, out_pdest,
    input  out_pdest_old, out_regWrite, free_count
  );

  // Rename stage itself
  modport slave (
    input  in_valid, srcReg1, srcReg2, destReg, regWrite,
    input  out_ready, free_valid, free_preg,
    output in_ready, out_valid, out_psrc1, out_psrc2, out_pdest,
    output out_pdest_old, out_regWrite, free_count
  );
endinterface

// File: rtl/rename_stage.sv
// Register rename stage: RAT lookup for sources, circular free-list
// allocation for the destination, registered hand-off to dispatch.
// Retired physical tags are pushed back at the free-list tail.
module rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PREG_W    = 6
) (
  input logic           clk,
  input logic           rstn,
  rename_stage_if.slave rif
);
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FL_W     = $clog2(FL_DEPTH);
  localparam logic [PREG_W:0]   FL_FULL = (PREG_W+1)'(FL_DEPTH);
  localparam logic [FL_W-1:0]   FL_LAST = FL_W'(FL_DEPTH - 1);

  // Architectural state
  logic [PREG_W-1:0] rat [ARCH_REGS];
  logic [PREG_W-1:0] fl  [FL_DEPTH];
  logic [FL_W-1:0]   head;
  logic [FL_W-1:0]   tail;
  logic [PREG_W:0]   free_count_q;

  // Handshake decode
  logic accept;
  logic alloc;
  logic push;

  // Stage 0: combinational rename results
  logic [PREG_W-1:0] psrc1_p0;
  logic [PREG_W-1:0] psrc2_p0;
  logic [PREG_W-1:0] pdest_p0;
  logic [PREG_W-1:0] pdest_old_p0;

  // Stage 1: registered output to dispatch
  logic              vld_p1;
  logic [PREG_W-1:0] psrc1_p1;
  logic [PREG_W-1:0] psrc2_p1;
  logic [PREG_W-1:0] pdest_p1;
  logic [PREG_W-1:0] pdest_old_p1;
  logic              rw_p1;

  // Circular pointer advance; explicit wrap keeps non-power-of-two depths correct
  function automatic logic [FL_W-1:0] ptr_inc(input logic [FL_W-1:0] p);
    return (p == FL_LAST) ? '0 : p + 1'b1;
  endfunction

  // Only the registered occupancy gates acceptance, so a same-cycle return
  // never opens the stage when the list is empty.
  assign rif.in_ready = (~vld_p1 | rif.out_ready) & (free_count_q != '0);
  assign accept       = rif.in_valid & rif.in_ready;
  assign alloc        = accept & rif.regWrite & (rif.destReg != '0);
  assign push         = rif.free_valid & (rif.free_preg != '0) & (free_count_q < FL_FULL);

  // Sources see the mapping from before this cycle's RAT write; x0 pinned to p0
  assign psrc1_p0     = (rif.srcReg1 == '0) ? '0 : rat[rif.srcReg1];
  assign psrc2_p0     = (rif.srcReg2 == '0) ? '0 : rat[rif.srcReg2];
  assign pdest_p0     = alloc ? fl[head] : '0;
  assign pdest_old_p0 = alloc ? rat[rif.destReg] : '0;

  // RAT: identity map at reset, destination remapped on allocation
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i] <= PREG_W'(i);
      end
    end else if (alloc) begin
      rat[rif.destReg] <= fl[head];
    end
  end

  // Free list: pop at head on allocation, push retired tags at tail
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl[i] <= PREG_W'(ARCH_REGS + i);
      end
      head         <= '0;
      tail         <= '0;
      free_count_q <= FL_FULL;
    end else begin
      if (alloc) begin
        head <= ptr_inc(head);
      end
      if (push) begin
        fl[tail] <= rif.free_preg;
        tail     <= ptr_inc(tail);
      end
      free_count_q <= free_count_q + (PREG_W+1)'(push) - (PREG_W+1)'(alloc);
    end
  end

  // Output register: load on accept, drain on dispatch, hold under back-pressure
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1       <= 1'b0;
      psrc1_p1     <= '0;
      psrc2_p1     <= '0;
      pdest_p1     <= '0;
      pdest_old_p1 <= '0;
      rw_p1        <= 1'b0;
    end else if (accept) begin
      vld_p1       <= 1'b1;
      psrc1_p1     <= psrc1_p0;
      psrc2_p1     <= psrc2_p0;
      pdest_p1     <= pdest_p0;
      pdest_old_p1 <= pdest_old_p0;
      rw_p1        <= alloc;
    end else if (rif.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign rif.out_valid     = vld_p1;
  assign rif.out_psrc1     = psrc1_p1;
  assign rif.out_psrc2     = psrc2_p1;
  assign rif.out_pdest     = pdest_p1;
  assign rif.out_pdest_old = pdest_old_p1;
  assign rif.out_regWrite  = rw_p1;
  assign rif.free_count    = free_count_q;
endmodule
